freq_gate_ctrl: RTL and testbench
=================================

# freq_gate_ctrl

Gate-time sequencer for the frequency counter. Runs on the reference clock and drives the 32-bit event counter's active-low clear and a gate enable that qualifies the measured signal into the counter's clock. Each measurement follows a fixed sequence:

1. Clear the counter.
2. Open the gate for exactly `GATE_CYCLES` reference cycles.
3. Wait a settle period.
4. Capture the counter value into a result register, offered with a valid/ack handshake.

## Interface

Parameters:

- `CLEAR_CYCLES`, default 2: reference cycles that `cnt_clear_n` is held low; must be ≥ 1.
- `GATE_CYCLES`, default 1000: reference cycles that `gate` is high (the measurement window); range 1 to 2^32−1.
- `SETTLE_CYCLES`, default 4: reference cycles between gate close and capture, so the last gated edge has propagated; must be ≥ 1.

Ports:

- `clock` in 1: reference clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request one measurement; sampled only in IDLE (or DONE with ack, see below).
- `count_in` in 32: counter output, unsigned.
- `result_ack` in 1: consumer accepts `result`.
- `cnt_clear_n` out 1: active-low clear to the counter.
- `gate` out 1: window enable, ANDed externally with the measured signal.
- `busy` out 1: high in CLEAR, GATE and SETTLE.
- `result` out 32: captured count.
- `result_valid` out 1: `result` is held and valid.
- `ovf` out 1: overflow flag for `result` (see Configuration).

## Operation

- All outputs are registered.
- Reset values: `cnt_clear_n`=0, `gate`=0, `busy`=0, `result`=0, `result_valid`=0, `ovf`=0, state IDLE.
- `cnt_clear_n` rises on the first edge after reset release.
- A single 32-bit phase counter times every state. It loads at state entry and counts down to 1.

State machine:

- **IDLE**: `gate`=0, `cnt_clear_n`=1.
  - `start`=1 → CLEAR.
- **CLEAR**: `cnt_clear_n`=0, `busy`=1, for `CLEAR_CYCLES` cycles.
  - Then → GATE.
- **GATE**: `gate`=1, `cnt_clear_n`=1, `busy`=1, for `GATE_CYCLES` cycles.
  - Then → SETTLE.
- **SETTLE**: `gate`=0, `busy`=1, for `SETTLE_CYCLES` cycles.
  - On the final edge, `result`←`count_in`, `result_valid`←1 → DONE.
- **DONE**: `result` and `result_valid` hold.
  - `result_ack`=1 → `result_valid`←0, go to IDLE.
  - `result_ack`=1 and `start`=1 on the same edge → go directly to CLEAR; `result_valid` drops on that edge.

Boundary conditions:

- `start` in CLEAR, GATE, SETTLE or DONE without ack is ignored. No queuing.
- `result_ack` outside DONE is ignored.
- Reset asserted mid-measurement forces all outputs to their reset values immediately (`gate` drops asynchronously). The partial count is discarded.
- The counter saturates at 32'hFFFFFFFF. `result` reports the saturated value unmodified.

## Timing

Let E0 be the edge where `start` is sampled high in IDLE, with C=`CLEAR_CYCLES`, G=`GATE_CYCLES`, S=`SETTLE_CYCLES`.

- `cnt_clear_n` is low from E0 to E0+C.
- `gate` is high from E0+C to E0+C+G: exactly G cycles.
- `result_valid` rises at E0+C+G+S, with `result` loaded on the same edge.
- With defaults this is E0+1006.
- `busy` is high from E0 to E0+C+G+S.
- Back-to-back measurements (ack and start on the same edge at E1): the next `cnt_clear_n` low begins at E1.

## Configuration

- `FREQ_GATE_OVF_EN` defined: at capture, `ovf`←(`count_in`==32'hFFFFFFFF). `ovf` is held with `result` and cleared when `result_valid` clears.
- `FREQ_GATE_OVF_EN` undefined: `ovf` is tied to 0 and no compare logic is built.

## Test plan

- **Defaults, 1-cycle `start` pulse, counter model counting 5 edges per gate cycle**:
  - `cnt_clear_n` low for exactly 2 cycles, `gate` high for exactly 1000 cycles.
  - `result_valid` at E0+1006 with `result`=5000.
- **`result_ack` withheld for 50 cycles**:
  - `result` and `result_valid` are stable throughout.
  - Ack → `result_valid`=0 next edge, state IDLE, `busy`=0.
- **`start` held high continuously with ack asserted in DONE**:
  - A new CLEAR begins on the ack edge.
  - `start` pulses during GATE cause no restart or change in window length.
- **`reset` low mid-GATE (cycle 400)**:
  - `gate`, `busy` and `result_valid` go to 0 immediately.
  - After release, a new `start` yields a full 1000-cycle window.
- **`GATE_CYCLES`=1, `count_in` forced to 32'hFFFFFFFF**:
  - `gate` high for exactly 1 cycle.
  - With `FREQ_GATE_OVF_EN` defined, `ovf`=1 and `result`=32'hFFFFFFFF.
  - Without the macro, `ovf`=0.

Source files
------------

// File: rtl/freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl
//
// Gate-time sequencer for a frequency counter, running on the reference clock.
// Each measurement follows the same sequence:
//   1. Clear the external event counter.
//   2. Open the gate for exactly GATE_CYCLES reference cycles.
//   3. Wait a settle period.
//   4. Capture the counter value into a result register.
// The captured result is offered to a consumer with a valid/ack handshake.
//
// Parameters:
//   CLEAR_CYCLES  : cycles cnt_clear_n is held low (>= 1)
//   GATE_CYCLES   : cycles gate is high, the measurement window (1 .. 2^32-1)
//   SETTLE_CYCLES : cycles between gate close and capture (>= 1)
//
// Ports:
//   clock        in   reference clock; all logic is on its rising edge
//   reset        in   asynchronous, active-low reset
//   start        in   request one measurement (IDLE, or DONE together with ack)
//   count_in     in   32-bit event counter value, unsigned
//   result_ack   in   consumer accepts result
//   cnt_clear_n  out  active-low clear to the event counter
//   gate         out  window enable, ANDed externally with the measured signal
//   busy         out  high during CLEAR, GATE and SETTLE
//   result       out  captured count
//   result_valid out  result is held and valid
//   ovf          out  overflow flag for result
//
// Build option:
//   FREQ_GATE_OVF_EN - when defined, ovf flags a saturated capture
//                      (count_in == 32'hFFFFFFFF). When undefined, ovf is
//                      tied to 0 and no compare logic is built.
// -----------------------------------------------------------------------------
module freq_gate_ctrl #(
  parameter int unsigned CLEAR_CYCLES  = 2,
  parameter int unsigned GATE_CYCLES   = 1000,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] count_in,
  input  logic        result_ack,
  output logic        cnt_clear_n,
  output logic        gate,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        ovf
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [31:0] L_CLEAR  = 32'(CLEAR_CYCLES);
  localparam logic [31:0] L_GATE   = 32'(GATE_CYCLES);
  localparam logic [31:0] L_SETTLE = 32'(SETTLE_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_phase;
  logic [31:0] w_phase_nxt;
  logic        w_phase_last;
  logic        w_capture;
  logic        w_release;

  logic        r_cnt_clear_n;
  logic        r_gate;
  logic        r_busy;
  logic [31:0] r_result;
  logic        r_result_valid;
  logic        w_cnt_clear_n_nxt;
  logic        w_gate_nxt;
  logic        w_busy_nxt;
  logic [31:0] w_result_nxt;
  logic        w_result_valid_nxt;

  // The single phase counter is loaded on state entry and counts down to 1;
  // the state is left on the edge where it reads 1.
  assign w_phase_last = (r_phase == 32'd1);

  // State and phase-counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_phase <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next-state and phase-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_CLEAR;
          w_phase_nxt = L_CLEAR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (w_phase_last) begin
          w_state_nxt = ST_GATE;
          w_phase_nxt = L_GATE;
        end else begin
          w_phase_nxt = r_phase - 32'd1;
        end
      end
      ST_GATE: begin
        if (w_phase_last) begin
          w_state_nxt = ST_SETTLE;
          w_phase_nxt = L_SETTLE;
        end else begin
          w_phase_nxt = r_phase - 32'd1;
        end
      end
      ST_SETTLE: begin
        if (w_phase_last) begin
          w_state_nxt = ST_DONE;
          w_phase_nxt = 32'd0;
          w_capture   = 1'b1;
        end else begin
          w_phase_nxt = r_phase - 32'd1;
        end
      end
      ST_DONE: begin
        if (result_ack) begin
          w_release = 1'b1;
          // Ack together with start chains straight into the next clear.
          if (start) begin
            w_state_nxt = ST_CLEAR;
            w_phase_nxt = L_CLEAR;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = 32'd0;
      end
    endcase
  end

  // Output decode from the next state so that the registered outputs line up
  // with the state they describe.
  always_comb begin
    w_cnt_clear_n_nxt = 1'b1;
    w_gate_nxt        = 1'b0;
    w_busy_nxt        = 1'b0;
    case (w_state_nxt)
      ST_CLEAR: begin
        w_cnt_clear_n_nxt = 1'b0;
        w_busy_nxt        = 1'b1;
      end
      ST_GATE: begin
        w_gate_nxt = 1'b1;
        w_busy_nxt = 1'b1;
      end
      ST_SETTLE: begin
        w_busy_nxt = 1'b1;
      end
      default: begin
        w_cnt_clear_n_nxt = 1'b1;
      end
    endcase

    if (w_capture) begin
      w_result_nxt       = count_in;
      w_result_valid_nxt = 1'b1;
    end else if (w_release) begin
      w_result_nxt       = r_result;
      w_result_valid_nxt = 1'b0;
    end else begin
      w_result_nxt       = r_result;
      w_result_valid_nxt = r_result_valid;
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt_clear_n  <= 1'b0;
      r_gate         <= 1'b0;
      r_busy         <= 1'b0;
      r_result       <= 32'd0;
      r_result_valid <= 1'b0;
    end else begin
      r_cnt_clear_n  <= w_cnt_clear_n_nxt;
      r_gate         <= w_gate_nxt;
      r_busy         <= w_busy_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
    end
  end

  assign cnt_clear_n  = r_cnt_clear_n;
  assign gate         = r_gate;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_result_valid;

`ifdef FREQ_GATE_OVF_EN
  logic r_ovf;
  logic w_ovf_nxt;

  // Overflow flag travels with result and clears together with result_valid.
  always_comb begin
    if (w_capture) begin
      w_ovf_nxt = (count_in == 32'hFFFF_FFFF);
    end else if (w_release) begin
      w_ovf_nxt = 1'b0;
    end else begin
      w_ovf_nxt = r_ovf;
    end
  end

  // Overflow flag register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_gate_ctrl
//
// Self-checking bench for freq_gate_ctrl. A behavioural event counter adds 5
// per gated reference cycle. Expected timing and result of each measurement
// are pushed to a scoreboard queue when start is driven and compared when
// result_valid rises. A second instance with GATE_CYCLES=1 sees a saturated
// counter value.
// -----------------------------------------------------------------------------
module tb_freq_gate_ctrl;

  localparam int C = 2;
  localparam int G = 1000;
  localparam int S = 4;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic [31:0] count_in;
  logic        result_ack;
  logic        cnt_clear_n;
  logic        gate;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        ovf;

  logic        start1;
  logic [31:0] count_in1;
  logic        ack1;
  logic        clr1;
  logic        gate1;
  logic        busy1;
  logic [31:0] res1;
  logic        valid1;
  logic        ovf1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          clr_len;
    int          gate_len;
    int          busy_len;
    int          valid_k;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int          ack_wait;
    int          start_k;
    int          ack_k;
    int          exp_clr;
    int          exp_gate;
    int          exp_valid_k;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[3];

  freq_gate_ctrl dut (
    .clock(clock), .reset(rst_n), .start(start), .count_in(count_in),
    .result_ack(result_ack), .cnt_clear_n(cnt_clear_n), .gate(gate),
    .busy(busy), .result(result), .result_valid(result_valid), .ovf(ovf)
  );

  freq_gate_ctrl #(.CLEAR_CYCLES(2), .GATE_CYCLES(1), .SETTLE_CYCLES(4)) dut1 (
    .clock(clock), .reset(rst_n), .start(start1), .count_in(count_in1),
    .result_ack(ack1), .cnt_clear_n(clr1), .gate(gate1),
    .busy(busy1), .result(res1), .result_valid(valid1), .ovf(ovf1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign count_in1 = 32'hFFFF_FFFF;

  // Behavioural event counter: 5 edges of the measured signal per gated cycle.
  always @(posedge clock) begin
    if (!cnt_clear_n) count_in <= 32'd0;
    else if (gate) count_in <= (count_in > 32'hFFFF_FFFA) ? 32'hFFFF_FFFF : count_in + 32'd5;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input int clr_len, input int gate_len, input int valid_k,
                          input logic [31:0] res);
    exp_t e;
    e.clr_len  = clr_len;
    e.gate_len = gate_len;
    e.busy_len = valid_k;
    e.valid_k  = valid_k;
    e.res      = res;
    sb.push_back(e);
  endtask

  // Pulse start in IDLE; returns at the negedge after the sampling edge E0.
  task automatic begin_meas(input int clr_len, input int gate_len, input int valid_k,
                            input logic [31:0] res);
    @(negedge clock);
    start = 1'b1;
    push_exp(clr_len, gate_len, valid_k, res);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Observe one measurement from k=0 (first negedge after E0) until result_valid.
  task automatic watch(input int start_k, input int ack_k);
    int clr_len = 0;
    int gate_len = 0;
    int busy_len = 0;
    int vk = -1;
    logic [31:0] res = 32'd0;
    exp_t e;
    for (int k = 0; k < 1200; k++) begin
      if (!cnt_clear_n) clr_len++;
      if (gate) gate_len++;
      if (busy) busy_len++;
      if (result_valid) begin
        vk  = k;
        res = result;
        break;
      end
      if (start_k >= 0 && k == start_k) start = 1'b1;
      else if (start_k >= 0 && k == start_k + 1) start = 1'b0;
      if (ack_k >= 0 && k == ack_k) result_ack = 1'b1;
      else if (ack_k >= 0 && k == ack_k + 1) result_ack = 1'b0;
      @(negedge clock);
    end
    if (vk < 0) check("valid_timeout", 32'd0, 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("clear_len", 32'(clr_len), 32'(e.clr_len));
      check("gate_len", 32'(gate_len), 32'(e.gate_len));
      check("busy_len", 32'(busy_len), 32'(e.busy_len));
      check("valid_latency", 32'(vk), 32'(e.valid_k));
      check("result", res, e.res);
    end
  endtask

  // Ack in DONE without start; the block must be back in IDLE one edge later.
  task automatic ack_to_idle(input string tag);
    result_ack = 1'b1;
    @(negedge clock);
    result_ack = 1'b0;
    check({tag, "_valid_after_ack"}, {31'd0, result_valid}, 32'd0);
    check({tag, "_busy_after_ack"}, {31'd0, busy}, 32'd0);
    check({tag, "_clrn_after_ack"}, {31'd0, cnt_clear_n}, 32'd1);
    check({tag, "_gate_after_ack"}, {31'd0, gate}, 32'd0);
  endtask

  initial begin
    int unstable;
    int g1;
    int vk1;
    logic [31:0] saved;
    logic exp_ovf;

    rst_n      = 1'b0;
    start      = 1'b0;
    result_ack = 1'b0;
    start1     = 1'b0;
    ack1       = 1'b0;

    // ack_wait, extra start pulse k, ack pulse k (in GATE), expected outputs
    vecs[0] = '{1,  -1,  -1,  C, G, C + G + S, 32'd5000};
    vecs[1] = '{50, 500, -1,  C, G, C + G + S, 32'd5000};
    vecs[2] = '{5,  -1,  300, C, G, C + G + S, 32'd5000};

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_clrn", {31'd0, cnt_clear_n}, 32'd0);
    check("rst_gate", {31'd0, gate}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clock);
    check("clrn_after_release", {31'd0, cnt_clear_n}, 32'd1);

    // Table-driven measurements
    foreach (vecs[i]) begin
      begin_meas(vecs[i].exp_clr, vecs[i].exp_gate, vecs[i].exp_valid_k, vecs[i].exp_res);
      watch(vecs[i].start_k, vecs[i].ack_k);
      saved = result;
      unstable = 0;
      for (int j = 0; j < vecs[i].ack_wait; j++) begin
        start = (j == 1);
        @(negedge clock);
        if (!result_valid || result !== saved || busy) unstable++;
      end
      start = 1'b0;
      check("hold_stable", 32'(unstable), 32'd0);
      ack_to_idle("vec");
    end

    // Back-to-back: start held high, ack in DONE starts the next clear at once
    @(negedge clock);
    start = 1'b1;
    push_exp(C, G, C + G + S, 32'd5000);
    @(negedge clock);
    watch(-1, -1);
    result_ack = 1'b1;
    push_exp(C, G, C + G + S, 32'd5000);
    @(negedge clock);
    result_ack = 1'b0;
    check("b2b_valid_drop", {31'd0, result_valid}, 32'd0);
    check("b2b_clear_at_ack", {31'd0, cnt_clear_n}, 32'd0);
    watch(-1, -1);
    start = 1'b0;
    ack_to_idle("b2b");

    // Reset mid-GATE at gate cycle 400
    begin_meas(C, G, C + G + S, 32'd5000);
    repeat (C + 400) @(negedge clock);
    check("gate_before_rst", {31'd0, gate}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_gate", {31'd0, gate}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_valid", {31'd0, result_valid}, 32'd0);
    check("rst_mid_clrn", {31'd0, cnt_clear_n}, 32'd0);
    sb.delete();
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    check("clrn_after_rst2", {31'd0, cnt_clear_n}, 32'd1);
    begin_meas(C, G, C + G + S, 32'd5000);
    watch(-1, -1);
    ack_to_idle("post_rst");

    // GATE_CYCLES=1 instance with a saturated counter
`ifdef FREQ_GATE_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    @(negedge clock);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    g1  = 0;
    vk1 = -1;
    for (int k = 0; k < 50; k++) begin
      if (gate1) g1++;
      if (valid1) begin
        vk1 = k;
        break;
      end
      @(negedge clock);
    end
    check("g1_gate_len", 32'(g1), 32'd1);
    check("g1_valid_latency", 32'(vk1), 32'(C + 1 + S));
    check("g1_result", res1, 32'hFFFF_FFFF);
    check("g1_ovf", {31'd0, ovf1}, {31'd0, exp_ovf});
    ack1 = 1'b1;
    @(negedge clock);
    ack1 = 1'b0;
    check("g1_valid_after_ack", {31'd0, valid1}, 32'd0);
    check("g1_ovf_after_ack", {31'd0, ovf1}, 32'd0);
    check("g1_busy_after_ack", {31'd0, busy1}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
